// File: rtl/mult_div_if.sv
// mult_div_if: operand/result bundle between the multicycle control unit and
// the HI/LO multiply/divide unit.
//   start    : request a new operation (only honoured while the unit is idle)
//   op       : 0 = signed multiply, 1 = signed divide
//   a, b     : operands (multiplicand/dividend, multiplier/divisor)
//   busy     : operation in flight
//   done     : one-cycle completion pulse
//   div_zero : last completed operation was a divide by zero
//   hi, lo   : result pair (product high/low, or remainder/quotient)
interface mult_div_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b,
                  input  busy, done, div_zero, hi, lo);

  modport slave  (input  start, op, a, b,
                  output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mult_div.sv
// mult_div: multicycle signed multiply / divide producing the HI/LO pair.
// Operands are reduced to magnitudes on acceptance, a 32-step unsigned
// shift-add multiply or restoring divide runs in CALC, and the signs are
// reapplied in SIGN. Total latency is 33 clocks from the accepting edge.
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : mult_div_if slave port (start/op/a/b in; busy/done/div_zero/hi/lo out)
module mult_div (
  input logic     clock,
  input logic     reset,
  mult_div_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t      state_q, state_d;
  logic        op_q, op_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        b_zero_q, b_zero_d;
  // Multiplicand for mult; for div it holds the dividend, which shifts out
  // MSB first while quotient bits shift in at the LSB.
  logic [31:0] abs_a_q, abs_a_d;
  logic [31:0] abs_b_q, abs_b_d;     // divisor magnitude (div only)
  // Mult: {partial product, remaining multiplier bits}.
  // Div : partial remainder in the low 33 bits.
  logic [63:0] acc_q, acc_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        div_zero_q, div_zero_d;

  logic [31:0] abs_a_in, abs_b_in;
  logic [32:0] mul_sum;
  logic [32:0] rem_shift;
  logic [32:0] rem_sub;
  logic        rem_ge;
  logic [63:0] prod_signed;

  // |0x80000000| wraps back to 0x80000000, which is the correct unsigned magnitude.
  assign abs_a_in = bus.a[31] ? (32'd0 - bus.a) : bus.a;
  assign abs_b_in = bus.b[31] ? (32'd0 - bus.b) : bus.b;

  // Multiply step: add the multiplicand into the high half when the current
  // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
  assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, abs_a_q} : 33'd0);

  // Divide step: bring down the next dividend bit and trial-subtract.
  assign rem_shift = {acc_q[31:0], abs_a_q[31]};
  assign rem_ge    = rem_shift >= {1'b0, abs_b_q};
  assign rem_sub   = rem_shift - {1'b0, abs_b_q};

  assign prod_signed = (sign_a_q ^ sign_b_q) ? (64'd0 - acc_q) : acc_q;

  // NOTE: every *_d gets its hold value first so no path through the case
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    b_zero_d   = b_zero_q;
    abs_a_d    = abs_a_q;
    abs_b_d    = abs_b_q;
    acc_d      = acc_q;
    count_d    = count_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d     = bus.op;
          sign_a_d = bus.a[31];
          sign_b_d = bus.b[31];
          b_zero_d = (bus.b == 32'd0);
          abs_a_d  = abs_a_in;
          abs_b_d  = abs_b_in;
          acc_d    = bus.op ? 64'd0 : {32'd0, abs_b_in};
          count_d  = 6'd0;
          state_d  = CALC;
        end
      end

      CALC: begin
        if (!op_q) begin
          acc_d = {mul_sum, acc_q[31:1]};
        end else begin
          acc_d   = {31'd0, (rem_ge ? rem_sub : rem_shift)};
          abs_a_d = {abs_a_q[30:0], rem_ge};
        end
        count_d = count_q + 6'd1;
        if (count_q == 6'd31) state_d = SIGN;
      end

      SIGN: begin
        if (!op_q) begin
          hi_d       = prod_signed[63:32];
          lo_d       = prod_signed[31:0];
          div_zero_d = 1'b0;
        end else if (b_zero_q) begin
          // Divide by zero keeps the previous HI/LO and only raises the flag.
          div_zero_d = 1'b1;
        end else begin
          // Quotient truncates toward zero; remainder follows the dividend sign.
          lo_d       = (sign_a_q ^ sign_b_q) ? (32'd0 - abs_a_q) : abs_a_q;
          hi_d       = sign_a_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
          div_zero_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state, including the datapath registers, is reset so that an
  // aborted operation leaves no trace; non-blocking assignments keep every
  // register updating from the same pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      b_zero_q   <= 1'b0;
      abs_a_q    <= 32'd0;
      abs_b_q    <= 32'd0;
      acc_q      <= 64'd0;
      count_q    <= 6'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      b_zero_q   <= b_zero_d;
      abs_a_q    <= abs_a_d;
      abs_b_q    <= abs_b_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: directed and randomized checks of mult_div against a reference
// model built on 64-bit signed integer arithmetic.
module tb_mult_div;

  logic clock;
  logic reset;

  mult_div_if bus ();

  mult_div dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference-model architectural state.
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;
  logic        exp_dz = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Signed HI/LO semantics from plain integer arithmetic: C-style truncating
  // division, remainder with the dividend's sign, divide by zero keeps HI/LO.
  task automatic model(input logic o, input logic [31:0] x, input logic [31:0] y);
    longint sa, sb, p, q, r;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    if (!o) begin
      p      = sa * sb;
      exp_hi = p[63:32];
      exp_lo = p[31:0];
      exp_dz = 1'b0;
    end else if (y == 32'd0) begin
      exp_dz = 1'b1;
    end else begin
      q      = sa / sb;
      r      = sa % sb;
      exp_lo = q[31:0];
      exp_hi = r[31:0];
      exp_dz = 1'b0;
    end
  endtask

  // Drive a request so it is accepted at the next rising edge, then drop start.
  task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    check("busy_after_accept", {63'd0, bus.busy}, 64'd1);
  endtask

  // Wait (bounded) for done; elapsed = clocks already spent since acceptance.
  task automatic finish(input string tag, input logic o, input logic [31:0] x,
                        input logic [31:0] y, input int elapsed);
    int cycles;
    cycles = elapsed;
    while (!bus.done && cycles < 100) begin
      @(posedge clock);
      #1;
      cycles++;
    end
    model(o, x, y);
    check({tag, "_latency"}, 64'(cycles), 64'd33);
    check({tag, "_hi"},      {32'd0, bus.hi}, {32'd0, exp_hi});
    check({tag, "_lo"},      {32'd0, bus.lo}, {32'd0, exp_lo});
    check({tag, "_divzero"}, {63'd0, bus.div_zero}, {63'd0, exp_dz});
    check({tag, "_busy_low"}, {63'd0, bus.busy}, 64'd0);
  endtask

  task automatic do_op(input string tag, input logic o, input logic [31:0] x,
                       input logic [31:0] y);
    @(negedge clock);
    issue(o, x, y);
    finish(tag, o, x, y, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    reset     = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Reset state.
    check("rst_busy",    {63'd0, bus.busy},     64'd0);
    check("rst_done",    {63'd0, bus.done},     64'd0);
    check("rst_divzero", {63'd0, bus.div_zero}, 64'd0);
    check("rst_hi",      {32'd0, bus.hi},       64'd0);
    check("rst_lo",      {32'd0, bus.lo},       64'd0);

    // Directed products and quotients.
    do_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD);
    check("mul_7_m3_hi_const", {32'd0, bus.hi}, 64'h0000_0000_FFFF_FFFF);
    check("mul_7_m3_lo_const", {32'd0, bus.lo}, 64'h0000_0000_FFFF_FFEB);
    @(posedge clock);
    #1;
    check("done_one_cycle", {63'd0, bus.done}, 64'd0);

    do_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000);
    check("mul_min_min_hi_const", {32'd0, bus.hi}, 64'h4000_0000);
    do_op("mul_m1_m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mul_m1_m1_lo_const", {32'd0, bus.lo}, 64'd1);
    do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2_hi_const", {32'd0, bus.hi}, 64'hFFFF_FFFF);
    do_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    check("div_7_m2_lo_const", {32'd0, bus.lo}, 64'hFFFF_FFFD);

    // Divide by zero keeps the previous product; the next divide clears the flag.
    do_op("mul_setup", 1'b0, 32'h1234_5678, 32'h0ABC_DEF1);
    do_op("div_by_zero", 1'b1, 32'd5, 32'd0);
    check("div_by_zero_flag", {63'd0, bus.div_zero}, 64'd1);
    do_op("div_9_3", 1'b1, 32'd9, 32'd3);
    check("div_9_3_lo_const", {32'd0, bus.lo}, 64'd3);

    // Overflow corner.
    do_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_min_m1_lo_const", {32'd0, bus.lo}, 64'h8000_0000);

    // start pulsed mid-CALC with other operands is ignored.
    @(negedge clock);
    issue(1'b0, 32'd1000, 32'hFFFF_FF9C);
    repeat (5) @(posedge clock);
    #1;
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a     = 32'd77;
    bus.b     = 32'd5;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    finish("ignored_start", 1'b0, 32'd1000, 32'hFFFF_FF9C, 6);

    // Back-to-back: start presented in the done cycle is accepted.
    do_op("b2b_first", 1'b1, 32'd100, 32'd7);
    issue(1'b0, 32'hFFFF_FFF0, 32'd3);
    finish("b2b_second", 1'b0, 32'hFFFF_FFF0, 32'd3, 0);

    // Reset mid-CALC at count 10 aborts without done.
    @(negedge clock);
    issue(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    exp_dz = 1'b0;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    check("abort_hi",   {32'd0, bus.hi},   64'd0);
    check("abort_lo",   {32'd0, bus.lo},   64'd0);
    @(negedge clock);
    reset = 1'b0;
    begin
      logic seen_done;
      seen_done = 1'b0;
      repeat (40) begin
        @(posedge clock);
        #1;
        seen_done = seen_done | bus.done;
      end
      check("abort_no_done", {63'd0, seen_done}, 64'd0);
    end
    do_op("mul_6_7", 1'b0, 32'd6, 32'd7);
    check("mul_6_7_lo_const", {32'd0, bus.lo}, 64'd42);

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      logic        o;
      logic [31:0] x, y;
      int          sel;
      o   = 1'($urandom_range(0, 1));
      x   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0)      y = 32'd0;
      else if (sel == 1) y = 32'($signed($urandom_range(0, 20)) - 10);
      else               y = $urandom;
      if ($urandom_range(0, 3) == 0) x = 32'($signed($urandom_range(0, 2000)) - 1000);
      do_op("rand", o, x, y);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
